// File: rtl/parity_frame_rx_pkg.sv
// Shared definitions for the serial parity frame receiver.
// Holds the receiver state encoding and the line-level constants used by the
// receiver and by anything that builds or checks frames for it.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam int DEFAULT_DATA_W = 8;
    localparam bit PARITY_EVEN    = 1'b0;
    localparam bit PARITY_ODD     = 1'b1;
    localparam bit LINE_IDLE      = 1'b1;
    localparam bit START_BIT      = 1'b0;

endpackage

// File: rtl/parity_frame_rx_if.sv
// Signal bundle between the serial line source and the frame receiver.
// Ports (signals):
//   x          serial line, one bit per clk, idles at 1
//   data       last received word, held until the next frame completes
//   valid      one-cycle pulse when data and the error flags update
//   parity_err parity mismatch for the frame flagged by valid
//   frame_err  stop bit was sampled as 0 for that frame
//   busy       receiver is somewhere inside a frame
// Handshake: there is no back-pressure. The line is consumed every clk, and
// valid is a single-cycle strobe; the downstream stage must take data,
// parity_err and frame_err in the cycle valid is high (they then hold).
// Modports: slave = receiver side, master = line source / consumer side.
interface parity_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              x;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  x,
        output data, valid, parity_err, frame_err, busy
    );

    modport master (
        output x,
        input  data, valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit,
// stop bit. Deserialises the word, checks parity and stop bit, and presents
// the word with a one-cycle valid pulse and held error flags.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    parity_frame_rx_if.slave (x in; data/valid/parity_err/frame_err/busy out)
//   state  current FSM state, exposed for observation
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit ODD_PARITY = PARITY_EVEN
) (
    input  logic                      clk,
    input  logic                      reset,
    parity_frame_rx_if.slave          bus,
    output rx_state_e                 state
);

    localparam int CNT_W = $clog2(DATA_W);

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               errp_q, errp_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            shift_q <= '0;
            errp_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            errp_q  <= errp_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        shift_d = shift_q;
        errp_d  = errp_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        case (state_q)
            IDLE: begin
                if (bus.x == START_BIT) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
            end
            DATA: begin
                // Shifting in at the MSB leaves the first data bit at bit 0.
                shift_d = {bus.x, shift_q[DATA_W-1:1]};
                acc_d   = acc_q ^ bus.x;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = PARITY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                errp_d  = ((acc_q ^ bus.x) != ODD_PARITY);
                state_d = STOP;
            end
            STOP: begin
                data_d  = shift_q;
                perr_d  = errp_q;
                ferr_d  = ~bus.x;
                valid_d = 1'b1;
                // No hunt for a new start edge: IDLE treats a low line as a start bit.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != IDLE);
    assign state          = state_q;

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
Serial frame receiver that sits directly downstream of the serial-bit parity stage.
- Consumes a one-bit-per-clock serial line `x` carrying start bit, data bits LSB first, parity bit and stop bit.
- Deserialises the data bits and checks them against the received parity bit and the stop bit.
- Presents a parallel word with a one-cycle valid pulse and error flags to the next stage.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..32).
- ODD_PARITY, 0, parity sense: 0 = even (data ones plus parity bit is even), 1 = odd.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- x  input  1  serial line, sampled once per clk; idle level 1.
- data  output  DATA_W  last received word; holds until the next frame completes.
- valid  output  1  one-cycle pulse when data and flags update.
- parity_err  output  1  parity mismatch for the frame flagged by valid; held with data.
- frame_err  output  1  stop bit sampled as 0 for that frame; held with data.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high (`reset`).
- Reset values: data=0, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, bit counter=0, parity accumulator=0.
- All outputs are registered. busy is decoded from the state register.

FSM (states IDLE, DATA, PARITY, STOP; all transitions on the clk edge):
- IDLE
  - x==0 is a start bit: go to DATA; clear counter and accumulator.
  - x==1: stay in IDLE.
- DATA
  - Shift x into the shift register at the MSB end, so after DATA_W bits the first received bit is bit 0.
  - Accumulator ^= x.
  - Counter increments each cycle.
  - When counter == DATA_W-1, go to PARITY.
- PARITY
  - Latch err_p = ((accumulator ^ x) != ODD_PARITY).
  - Go to STOP.
- STOP
  - data <= shift register, parity_err <= err_p, frame_err <= ~x, valid <= 1.
  - Go to IDLE.
- valid is 0 in every cycle other than the one following the STOP edge.

Timing and latency:
- With the start bit sampled at edge k, the data bits are sampled at edges k+1..k+DATA_W.
- The parity bit is sampled at edge k+DATA_W+1 and the stop bit at edge k+DATA_W+2.
- valid is high for exactly the one cycle after edge k+DATA_W+2.

Boundary conditions:
- Back-to-back frames: a start bit is accepted at the edge immediately after STOP, with zero idle cycles. valid for frame n and the start of frame n+1 may coincide; they must not interfere.
- Frame error: valid still pulses; data and parity_err are reported normally. No resynchronisation hunt — the FSM simply returns to IDLE, where a line still at 0 is taken as a new start bit.
- Simultaneous parity and framing error: both flags are set.
- Reset mid-frame: the frame is aborted with no valid pulse, and all outputs and state return to reset values on that edge.
- Arithmetic width: the counter is $clog2(DATA_W) bits wide and never wraps past DATA_W-1.
- Unused states decode to IDLE.

Decomposition:
- Package parity_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - constants DEFAULT_DATA_W=8, PARITY_EVEN=0, PARITY_ODD=1, LINE_IDLE=1, START_BIT=0.
- No sub-module. The shift register, counter and parity accumulator are small enough to live inline.

Test Plan (DATA_W=8, even parity unless stated):
1. Reset, then line held at 1 for 5 cycles, then frame 0 | 1,0,1,0,0,1,0,1 | 0 | 1 (0xA5). Required: data=0xA5, valid for exactly 1 cycle, 11 cycles after the start edge; parity_err=0, frame_err=0; busy high 10 cycles.
2. Frame 0x01 with parity bit 0 and stop bit 1. Required: valid=1, data=0x01, parity_err=1, frame_err=0.
3. Frame 0x3C with parity bit 0 and stop bit 0. Required: valid=1, data=0x3C, frame_err=1, parity_err=0. The FSM re-enters DATA next cycle only if x is still 0.
4. Back-to-back frames 0x3C then 0xFF, both with parity bit 0 and no idle gap. Required: two valid pulses 11 cycles apart; data 0x3C then 0xFF; no error flags.
5. Assert reset for 1 cycle after the 3rd data bit of a frame, then send clean frame 0x5A. Required: no valid for the aborted frame; all outputs 0 after reset; then data=0x5A, valid=1, no errors.
6. ODD_PARITY=1, frame 0x07 with parity bit 0, then 0x07 with parity bit 1. Required: parity_err=0, then parity_err=1.
